// File: rtl/pause_req_gen.sv
// pause_req_gen: frame-aligned pause request generator.
//
// Debounces the pause/resume buttons and steps a four-state pause FSM.
// Entry to and exit from pause wait for a vblank rising edge, so a frame
// is never frozen mid-scan. A timeout forces the transition if the core's
// video timing has stopped.
//
// Ports:
//   clk_sys     in   system clock
//   reset       in   asynchronous active-high reset
//   btn_pause   in   raw pause button (async)
//   btn_resume  in   raw resume button (async)
//   vblank      in   core vblank, clk_sys domain
//   pause_en    in   0 forces RUN and drops all requests
//   pause_req   out  registered pause request (PAUSED / ARM_RESUME)
//   pause_state out  FSM state: 0=RUN 1=ARM_PAUSE 2=PAUSED 3=ARM_RESUME
//   dim_video   out  dim request after DIM_FRAMES paused frames
//
// Optional feature macro: PAUSE_DIM_EN (frame counter + dim_video).
// Without it dim_video is tied 0.

// Per-button synchronizer + debouncer. The press pulse is combinational
// and aligned with the edge on which the debounced level flips.
module pause_req_gen_deb #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          hit;

  assign hit   = (cnt == CW'(DEBOUNCE_CYCLES));
  assign press = hit & sync[1] & ~level;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (hit) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module pause_req_gen #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int VBL_TIMEOUT     = 2000000,
  parameter int DIM_FRAMES      = 600
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_resume,
  input  logic       vblank,
  input  logic       pause_en,
  output logic       pause_req,
  output logic [1:0] pause_state,
  output logic       dim_video
);
  localparam int NUM_BTN = 2;
  localparam int WW      = (VBL_TIMEOUT > 1) ? $clog2(VBL_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    ARM_PAUSE  = 2'd1,
    PAUSED     = 2'd2,
    ARM_RESUME = 2'd3
  } state_t;

  state_t               state;
  logic [WW-1:0]        wcnt;
  logic                 vblank_d;
  logic                 vbl_rise;
  logic                 tmo;
  logic [NUM_BTN-1:0]   raw;
  logic [NUM_BTN-1:0]   press;
  logic                 pause_press;
  logic                 resume_press;

  // bit 0 = pause, bit 1 = resume
  assign raw = {btn_resume, btn_pause};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    pause_req_gen_deb #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_sys (clk_sys),
      .reset   (reset),
      .raw     (raw[i]),
      .press   (press[i])
    );
  end

  assign pause_press  = press[0];
  assign resume_press = press[1];
  assign vbl_rise     = vblank & ~vblank_d;
  assign tmo          = (wcnt == WW'(VBL_TIMEOUT - 1));
  assign pause_state  = state;

  // Only the ARM states let wcnt run; every transition zeroes it, so an
  // ARM state always times out VBL_TIMEOUT cycles after it was entered.
  // A vbl_rise on the entry edge is seen while still in RUN/PAUSED and is
  // therefore ignored, which makes the FSM wait for the following frame.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wcnt      <= '0;
      vblank_d  <= 1'b0;
      pause_req <= 1'b0;
    end else begin
      vblank_d  <= vblank;
      // Follows the state register one cycle late, except that pause_en=0
      // drops it on the same edge as the forced return to RUN.
      pause_req <= pause_en & ((state == PAUSED) | (state == ARM_RESUME));
      if (!pause_en) begin
        state <= RUN;
        wcnt  <= '0;
      end else begin
        case (state)
          RUN: begin
            wcnt <= '0;
            if (pause_press) state <= ARM_PAUSE;
          end
          ARM_PAUSE: begin
            if (pause_press) begin
              state <= RUN;
              wcnt  <= '0;
            end else if (vbl_rise | tmo) begin
              state <= PAUSED;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          PAUSED: begin
            wcnt <= '0;
            if (pause_press | resume_press) state <= ARM_RESUME;
          end
          ARM_RESUME: begin
            if (vbl_rise | tmo) begin
              state <= RUN;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef PAUSE_DIM_EN
  localparam int FW = $clog2(DIM_FRAMES + 1);

  logic [FW-1:0] fcnt;
  logic          leave_paused;

  assign leave_paused = (state == PAUSED) &
                        (~pause_en | pause_press | resume_press);

  // dim_video rises on the same edge the count reaches DIM_FRAMES and
  // clears on the edge that leaves PAUSED.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fcnt      <= '0;
      dim_video <= 1'b0;
    end else if ((state != PAUSED) || leave_paused) begin
      fcnt      <= '0;
      dim_video <= 1'b0;
    end else if (vbl_rise && (fcnt != FW'(DIM_FRAMES))) begin
      fcnt      <= fcnt + 1'b1;
      dim_video <= ((fcnt + 1'b1) == FW'(DIM_FRAMES));
    end
  end
`else
  assign dim_video = 1'b0;
`endif

endmodule

// File: tb/tb_pause_req_gen.sv
// Scoreboard bench for pause_req_gen. The stimulus thread drives inputs on
// the falling edge and pushes {cycle, state, req, dim} expectations; the
// monitor samples on the falling edge, pops entries whose cycle is due and
// flags any output change that no entry predicted. vblank is a 50-cycle
// generator whose rising edges are seen by the DUT on cycles 50k+1.
module tb_pause_req_gen;
  logic       clk_sys = 1'b0;
  logic       reset;
  logic       btn_pause, btn_resume, vblank, pause_en;
  logic       pause_req, dim_video;
  logic [1:0] pause_state;

  typedef struct {
    int         cyc;
    logic [3:0] val;   // {state, req, dim}
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   vbl_on = 1'b0;
  bit   done = 1'b0;
  logic [3:0] prev = 4'h0;

`ifdef PAUSE_DIM_EN
  localparam logic DIM_HI = 1'b1;
`else
  localparam logic DIM_HI = 1'b0;
`endif

  pause_req_gen #(
    .DEBOUNCE_CYCLES (4),
    .VBL_TIMEOUT     (100),
    .DIM_FRAMES      (3)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .btn_pause   (btn_pause),
    .btn_resume  (btn_resume),
    .vblank      (vblank),
    .pause_en    (pause_en),
    .pause_req   (pause_req),
    .pause_state (pause_state),
    .dim_video   (dim_video)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    vblank = 1'b0;
    forever begin
      @(negedge clk_sys);
      vblank = vbl_on && ((cyc % 50) < 5);
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_sys);
  endtask

  task automatic push(input int c, input logic [1:0] s, input logic r,
                      input logic d, input string tag);
    exp_t e;
    e.cyc = c;
    e.val = {s, r, d};
    e.tag = tag;
    q.push_back(e);
  endtask

  // monitor / scoreboard
  always @(negedge clk_sys) begin
    logic [3:0] o;
    exp_t       e;
    o = {pause_state, pause_req, dim_video};
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL pending_expectations left=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missed at cyc=%0d", e.tag, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d got state=%0d req=%b dim=%b required state=%0d req=%b dim=%b",
                 e.tag, cyc, o[3:2], o[1], o[0], e.val[3:2], e.val[1], e.val[0]);
      end
    end else if (o !== prev) begin
      checks++;
      errors++;
      $display("FAIL unexpected_change cyc=%0d got state=%0d req=%b dim=%b was state=%0d req=%b dim=%b",
               cyc, o[3:2], o[1], o[0], prev[3:2], prev[1], prev[0]);
    end
    prev = o;
  end

  initial begin
    reset = 1'b1; btn_pause = 1'b0; btn_resume = 1'b0; pause_en = 1'b1;
    wait_to(2);
    push(3, 2'd0, 1'b0, 1'b0, "reset_state");
    wait_to(4);
    reset = 1'b0;
    vbl_on = 1'b1;
    push(254, 2'd0, 1'b0, 1'b0, "idle_mid");
    push(504, 2'd0, 1'b0, 1'b0, "idle_end");

    // pause press, vblank-aligned entry, dim build-up, resume
    wait_to(510); btn_pause = 1'b1;
    push(517, 2'd1, 1'b0, 1'b0, "arm_pause");
    push(551, 2'd2, 1'b0, 1'b0, "paused_on_vbl");
    push(552, 2'd2, 1'b1, 1'b0, "req_rise");
    wait_to(520); btn_pause = 1'b0;
    if (DIM_HI) push(701, 2'd2, 1'b1, 1'b1, "dim_after_3_frames");
    wait_to(720); btn_resume = 1'b1;
    push(727, 2'd3, 1'b1, 1'b0, "arm_resume");
    push(751, 2'd0, 1'b1, 1'b0, "run_on_vbl");
    push(752, 2'd0, 1'b0, 1'b0, "req_fall");
    wait_to(730); btn_resume = 1'b0;

    // 3-cycle glitch is filtered
    wait_to(800); btn_pause = 1'b1;
    wait_to(803); btn_pause = 1'b0;
    push(850, 2'd0, 1'b0, 1'b0, "glitch_ignored");

    // vblank stopped: timeout forces PAUSED 100 cycles after ARM entry
    wait_to(860); vbl_on = 1'b0;
    wait_to(870); btn_pause = 1'b1;
    push(877, 2'd1, 1'b0, 1'b0, "arm_pause_novbl");
    push(977, 2'd2, 1'b0, 1'b0, "timeout_paused");
    push(978, 2'd2, 1'b1, 1'b0, "timeout_req");
    wait_to(880); btn_pause = 1'b0;

    // pause_en drop while PAUSED, presses discarded while disabled
    wait_to(1000); pause_en = 1'b0;
    push(1001, 2'd0, 1'b0, 1'b0, "en_drop_paused");
    push(1040, 2'd0, 1'b0, 1'b0, "press_while_disabled");
    wait_to(1005); btn_pause = 1'b1;
    wait_to(1015); btn_pause = 1'b0;
    wait_to(1030); pause_en = 1'b1;

    // cancel from ARM_PAUSE
    wait_to(1050); btn_pause = 1'b1;
    push(1057, 2'd1, 1'b0, 1'b0, "arm_before_cancel");
    wait_to(1060); btn_pause = 1'b0;
    wait_to(1070); btn_pause = 1'b1;
    push(1077, 2'd0, 1'b0, 1'b0, "cancel");
    push(1200, 2'd0, 1'b0, 1'b0, "cancel_holds");
    wait_to(1080); btn_pause = 1'b0;

    // vbl_rise on the ARM entry edge is not consumed
    wait_to(1210); vbl_on = 1'b1;
    wait_to(1294); btn_pause = 1'b1;
    push(1301, 2'd1, 1'b0, 1'b0, "arm_on_vbl_edge");
    push(1351, 2'd2, 1'b0, 1'b0, "paused_next_vbl");
    push(1352, 2'd2, 1'b1, 1'b0, "req_rise2");
    wait_to(1304); btn_pause = 1'b0;

    // pause button also resumes
    wait_to(1360); btn_pause = 1'b1;
    push(1367, 2'd3, 1'b1, 1'b0, "arm_resume_by_pause");
    push(1401, 2'd0, 1'b1, 1'b0, "run_on_vbl2");
    push(1402, 2'd0, 1'b0, 1'b0, "req_fall2");
    wait_to(1370); btn_pause = 1'b0;

    // pause_en drop mid-ARM_RESUME releases at once
    wait_to(1420); btn_pause = 1'b1;
    push(1427, 2'd1, 1'b0, 1'b0, "arm_pause3");
    push(1451, 2'd2, 1'b0, 1'b0, "paused3");
    push(1452, 2'd2, 1'b1, 1'b0, "req_rise3");
    wait_to(1430); btn_pause = 1'b0;
    wait_to(1460); btn_resume = 1'b1;
    push(1467, 2'd3, 1'b1, 1'b0, "arm_resume3");
    wait_to(1470); btn_resume = 1'b0; pause_en = 1'b0;
    push(1471, 2'd0, 1'b0, 1'b0, "en_drop_arm_resume");
    wait_to(1480); pause_en = 1'b1;

    // reset mid-pause
    wait_to(1500); btn_pause = 1'b1;
    push(1507, 2'd1, 1'b0, 1'b0, "arm_pause4");
    push(1551, 2'd2, 1'b0, 1'b0, "paused4");
    push(1552, 2'd2, 1'b1, 1'b0, "req_rise4");
    wait_to(1510); btn_pause = 1'b0;
    wait_to(1560);
    push(1561, 2'd0, 1'b0, 1'b0, "reset_mid_pause");
    #2 reset = 1'b1;
    wait_to(1570); reset = 1'b0;
    push(1600, 2'd0, 1'b0, 1'b0, "after_reset");
    wait_to(1610);
    done = 1'b1;
  end
endmodule

// File: doc/pause_req_gen.md
Name: pause_req_gen

Overview:
- Generates the frame-aligned `pause_req` that feeds the core pause controller, which ORs it with the synchronized OS menu flag to produce `pause_core`.
- Debounces the user pause and resume buttons and toggles a pause state.
- Aligns pause entry and exit to vblank rising edges so a frame is never frozen mid-scan.
- A timeout fallback covers cores whose video timing stops.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive stable `clk_sys` cycles a synced button level must hold before it is accepted.
- VBL_TIMEOUT, 2000000: max `clk_sys` cycles spent waiting for a vblank edge in an ARM state before the transition is forced.
- DIM_FRAMES, 600: paused vblank edges before `dim_video` asserts (only with PAUSE_DIM_EN).

Ports:
- clk_sys  in  1  system clock; everything in this domain.
- reset  in  1  asynchronous, active-high reset.
- btn_pause  in  1  raw pause button, asynchronous, active-high.
- btn_resume  in  1  raw resume button (e.g. start), asynchronous, active-high.
- vblank  in  1  core vblank, already in `clk_sys` domain, active-high.
- pause_en  in  1  user-menu enable for pausing; 0 disables the block.
- pause_req  out  1  registered pause request to the pause controller.
- pause_state  out  2  FSM state: 0=RUN, 1=ARM_PAUSE, 2=PAUSED, 3=ARM_RESUME.
- dim_video  out  1  request video dimming after a long pause.

Behaviour:
- Reset (async, active-high): state RUN; `pause_req`=0; `pause_state`=0; `dim_video`=0; sync flops, debounced levels and all counters cleared.
- Input sync: `btn_pause` and `btn_resume` each pass through a 2-flop synchronizer.
- Debounce: a per-button counter of width clog2(DEBOUNCE_CYCLES+1).
  - While the synced level differs from the debounced level, the counter increments; it clears whenever they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synced level and the counter clears.
  - A press is a 1-cycle pulse on the debounced 0->1 edge.
  - Latency from a raw edge to the press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- vblank edge: `vbl_rise` = vblank & ~vblank_d, where vblank_d is a 1-cycle register.
- Wait counter: counts cycles in ARM_PAUSE/ARM_RESUME; clears on every state change; `tmo` = count reaches VBL_TIMEOUT-1.
- FSM transitions, with `pause_en`=1:
  - RUN: pause press -> ARM_PAUSE. Resume press is ignored.
  - ARM_PAUSE: pause press -> RUN (cancel, takes priority). Otherwise `vbl_rise` or `tmo` -> PAUSED.
  - PAUSED: pause press or resume press -> ARM_RESUME.
  - ARM_RESUME: `vbl_rise` or `tmo` -> RUN. Button presses are ignored.
- A `vbl_rise` in the same cycle the FSM enters an ARM state is not consumed; the FSM waits for the next one.
- Outputs:
  - `pause_req` is registered: 1 in PAUSED and ARM_RESUME, else 0. It rises the cycle after the PAUSED transition and falls the cycle after the RUN transition.
  - `pause_state` is registered and mirrors the FSM.
- `pause_en`=0, checked synchronously with highest priority: next state RUN, wait and dim counters cleared. `pause_req` and `dim_video` are 0 from the next cycle. Presses are discarded while `pause_en`=0; debounce keeps running.
- `pause_en` dropping mid-ARM_RESUME or mid-PAUSED releases pause immediately without vblank alignment.
- Reset asserted mid-operation returns everything to reset values asynchronously.

Optional Feature:
- Macro: PAUSE_DIM_EN.
- Defined:
  - A frame counter of width clog2(DIM_FRAMES+1) increments on `vbl_rise` while in PAUSED, saturating at DIM_FRAMES.
  - `dim_video` is registered and equals 1 when the count equals DIM_FRAMES.
  - The counter and `dim_video` clear on leaving PAUSED.
- Not defined: the counter is absent; `dim_video` is tied 0.

Test Plan (DEBOUNCE_CYCLES=4, VBL_TIMEOUT=100, DIM_FRAMES=3, vblank period 50 cycles):
- Reset release, no inputs -> `pause_req`=0 and `pause_state`=0 for 500 cycles.
- `btn_pause` high for 10 cycles, then low:
  - `pause_state`=1 at 7 cycles after the edge.
  - `pause_state`=2 the cycle after the next `vbl_rise`.
  - `pause_req`=1 one cycle later.
- While PAUSED, resume press -> `pause_state`=3, `pause_req` stays 1. At the next `vbl_rise`: `pause_state`=0 then `pause_req`=0 one cycle later.
- `btn_pause` glitch of 3 cycles -> no state change. Vblank held low after a valid press -> PAUSED forced exactly 100 cycles after entering ARM_PAUSE.
- Second pause press while ARM_PAUSE -> back to RUN, `pause_req` never asserted. `pause_en`=0 while PAUSED -> `pause_req`=0 next cycle, state 0.
- PAUSE_DIM_EN defined, held PAUSED -> `dim_video`=1 after the 3rd `vbl_rise`, cleared on the ARM_RESUME entry. Undefined -> `dim_video` always 0.
